// File: rtl/tlk2711_axil_reg_bridge.sv
// tlk2711_axil_reg_bridge
//   AXI4-Lite slave that turns single-beat reads and writes into one-cycle
//   register strobes for the TLK2711 register manager. Exactly one transaction
//   is in flight at a time. When a write and a read contend, they take turns.
//
// Parameters
//   AXIL_ADDR_WIDTH  AXI byte address width (>= 16); only bits [15:0] are used
//   RD_LATENCY       cycles from o_reg_ren to valid i_reg_rdata (1..4)
//   ADDR_MASK        offset mask of the register window
//   ADDR_BASE        base of the register window
//
// Ports
//   ps_clk, ps_rst          clock, synchronous active-high reset
//   s_axil_aw*/w*/b*        AXI4-Lite write address / data / response channels
//   s_axil_ar*/r*           AXI4-Lite read address / data channels
//   o_reg_wen/waddr/wdata   register write strobe, address, data
//   o_reg_ren/raddr         register read strobe, address
//   i_reg_rdata             register read data, RD_LATENCY cycles after o_reg_ren
//
// Build option
//   TLK2711_AXIL_ADDR_CHECK_EN  when defined, addresses outside the window get
//                               no strobe and a DECERR response (read data 0).

module tlk2711_axil_reg_bridge #(
   parameter int unsigned AXIL_ADDR_WIDTH = 16,
   parameter int unsigned RD_LATENCY      = 1,
   parameter logic [15:0] ADDR_MASK       = 16'h00ff,
   parameter logic [15:0] ADDR_BASE       = 16'h0000
) (
   input  logic                       ps_clk,
   input  logic                       ps_rst,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   input  logic [63:0]                s_axil_wdata,
   input  logic [7:0]                 s_axil_wstrb,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   output logic [1:0]                 s_axil_bresp,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready,
   output logic [63:0]                s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       o_reg_wen,
   output logic [15:0]                o_reg_waddr,
   output logic [63:0]                o_reg_wdata,
   output logic                       o_reg_ren,
   output logic [15:0]                o_reg_raddr,
   input  logic [63:0]                i_reg_rdata
);

   typedef enum logic [2:0] {StIdle, StWrStb, StWrRsp, StRdStb, StRdWait, StRdRsp} state_e;

   localparam logic [2:0] WaitLast = 3'(RD_LATENCY - 1);

   state_e      state_q, state_d;
   logic        aw_held_q, w_held_q;
   logic        wr_prio_q;              // 1: write wins the next contest
   logic [15:0] aw_addr_q, ar_addr_q;
   logic [63:0] wdata_q;
   logic [7:0]  wstrb_q;
   logic [2:0]  wait_cnt_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [63:0] rdata_q;

   logic idle, aw_hs, w_hs, ar_hs, wr_pend, wr_go, contest;
   logic wr_addr_ok, rd_addr_ok, wr_strb_ok;

`ifdef TLK2711_AXIL_ADDR_CHECK_EN
   assign wr_addr_ok = (aw_addr_q & ~ADDR_MASK) == ADDR_BASE;
   assign rd_addr_ok = (ar_addr_q & ~ADDR_MASK) == ADDR_BASE;
`else
   logic unused_cfg;
   assign unused_cfg = ^{ADDR_MASK, ADDR_BASE};
   assign wr_addr_ok = 1'b1;
   assign rd_addr_ok = 1'b1;
`endif

   if (AXIL_ADDR_WIDTH > 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{s_axil_awaddr[AXIL_ADDR_WIDTH-1:16],
                                s_axil_araddr[AXIL_ADDR_WIDTH-1:16]};
   end

   assign wr_strb_ok = (wstrb_q == 8'hff);

   // Readies are held low during reset even though the FSM already sits in IDLE.
   assign idle           = (state_q == StIdle) && !ps_rst;
   assign s_axil_awready = idle && !aw_held_q;
   assign s_axil_wready  = idle && !w_held_q;
   assign aw_hs          = s_axil_awvalid && s_axil_awready;
   assign w_hs           = s_axil_wvalid && s_axil_wready;
   // A write counts as complete in the same cycle its last half is accepted.
   assign wr_pend        = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign s_axil_arready = idle && !(wr_pend && wr_prio_q);
   assign ar_hs          = s_axil_arvalid && s_axil_arready;
   assign wr_go          = wr_pend && !ar_hs;
   assign contest        = idle && wr_pend && s_axil_arvalid;

   // State register
   always_ff @(posedge ps_clk) begin
      if (ps_rst) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (ar_hs)      state_d = StRdStb;
            else if (wr_go) state_d = StWrStb;
         end
         StWrStb:  state_d = StWrRsp;
         StWrRsp:  if (s_axil_bready) state_d = StIdle;
         StRdStb:  state_d = StRdWait;
         StRdWait: if (wait_cnt_q == WaitLast) state_d = StRdRsp;
         StRdRsp:  if (s_axil_rready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      o_reg_wen     = (state_q == StWrStb) && wr_strb_ok && wr_addr_ok;
      o_reg_ren     = (state_q == StRdStb) && rd_addr_ok;
      s_axil_bvalid = (state_q == StWrRsp);
      s_axil_rvalid = (state_q == StRdRsp);
   end

   assign o_reg_waddr  = aw_addr_q;
   assign o_reg_wdata  = wdata_q;
   assign o_reg_raddr  = ar_addr_q;
   assign s_axil_bresp = bresp_q;
   assign s_axil_rresp = rresp_q;
   assign s_axil_rdata = rdata_q;

   // Channel latches, arbiter and response registers
   always_ff @(posedge ps_clk) begin
      if (ps_rst) begin
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         wr_prio_q  <= 1'b1;
         aw_addr_q  <= '0;
         ar_addr_q  <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wait_cnt_q <= '0;
         bresp_q    <= '0;
         rresp_q    <= '0;
         rdata_q    <= '0;
      end else begin
         if (aw_hs) begin
            aw_addr_q <= s_axil_awaddr[15:0];
            aw_held_q <= 1'b1;
         end
         if (w_hs) begin
            wdata_q  <= s_axil_wdata;
            wstrb_q  <= s_axil_wstrb;
            w_held_q <= 1'b1;
         end
         // Latched data stays put for WR_STB; only the pending flags drop.
         if ((state_q == StIdle) && wr_go) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end
         if (ar_hs) ar_addr_q <= s_axil_araddr[15:0];
         if (contest) wr_prio_q <= ~wr_prio_q;

         if (state_q == StWrStb) begin
            if (!wr_addr_ok)      bresp_q <= 2'b11;
            else if (!wr_strb_ok) bresp_q <= 2'b10;
            else                  bresp_q <= 2'b00;
         end

         // RD_WAIT spans RD_LATENCY cycles; its last cycle is when read data is valid.
         if (state_q == StRdStb) wait_cnt_q <= '0;
         if (state_q == StRdWait) begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
            if (wait_cnt_q == WaitLast) begin
               rdata_q <= rd_addr_ok ? i_reg_rdata : 64'h0;
               rresp_q <= rd_addr_ok ? 2'b00 : 2'b11;
            end
         end
      end
   end

endmodule
